// File: rtl/addsub_operand_ctrl.sv
// ============================================================================
// Module   : addsub_operand_ctrl
// Purpose  : Debounced operand-entry sequencer for a 4-bit add/sub datapath;
//            optional overflow flag enabled by macro ADDSUB_OVF_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_operand_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int CNT_W           = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_enter_n,
   input  logic       key_clear_n,
   input  logic [3:0] sw_data,
   input  logic       sw_sub,
   input  logic [3:0] adder_r,
   input  logic       adder_cout,
   output logic [3:0] op_a,
   output logic [3:0] op_b,
   output logic       op_sub,
   output logic [3:0] disp_nibble,
   output logic [1:0] state_led,
   output logic       result_valid,
   output logic       carry_led
`ifdef ADDSUB_OVF_DETECT_EN
   ,
   output logic       ovf_led
`endif
);

   localparam logic [1:0]       c_GET_A   = 2'b00;
   localparam logic [1:0]       c_GET_B   = 2'b01;
   localparam logic [1:0]       c_CALC    = 2'b10;
   localparam logic [1:0]       c_SHOW    = 2'b11;
   localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0] w_key_raw;
   logic [1:0] w_press;
   logic       w_enter;
   logic       w_clear;

   assign w_key_raw = {key_clear_n, key_enter_n};
   assign w_enter   = w_press[0];
   assign w_clear   = w_press[1];

   // Bit 0 is enter, bit 1 is clear; both keys share the same debounce path.
   generate
      for (genvar k = 0; k < 2; k++) begin : g_key
         logic             r_sync1;
         logic             r_sync2;
         logic             r_deb;
         logic             r_press;
         logic [CNT_W-1:0] r_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sync1 <= 1'b1;
               r_sync2 <= 1'b1;
               r_deb   <= 1'b1;
               r_press <= 1'b0;
               r_cnt   <= '0;
            end else begin
               r_sync1 <= w_key_raw[k];
               r_sync2 <= r_sync1;
               r_press <= 1'b0;
               if (r_sync2 == r_deb) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_CNT_MAX) begin
                  r_cnt   <= '0;
                  r_deb   <= r_sync2;
                  r_press <= r_deb;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end

         assign w_press[k] = r_press;
      end
   endgenerate

   logic [1:0] r_state;
   logic [3:0] r_op_a;
   logic [3:0] r_op_b;
   logic       r_op_sub;
   logic [3:0] r_res;
   logic       r_carry;
   logic       r_result_valid;

`ifdef ADDSUB_OVF_DETECT_EN
   logic       r_ovf;
   logic [3:0] w_b_eff;
   logic       w_ovf;

   // Signed overflow: effective operands agree in sign but the result does not.
   assign w_b_eff = r_op_b ^ {4{r_op_sub}};
   assign w_ovf   = (r_op_a[3] == w_b_eff[3]) && (adder_r[3] != r_op_a[3]);
   assign ovf_led = r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_clear) begin
         r_ovf <= 1'b0;
      end else if (r_state == c_CALC) begin
         r_ovf <= w_ovf;
      end else if ((r_state == c_SHOW) && w_enter) begin
         r_ovf <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= c_GET_A;
         r_op_a         <= '0;
         r_op_b         <= '0;
         r_op_sub       <= 1'b0;
         r_res          <= '0;
         r_carry        <= 1'b0;
         r_result_valid <= 1'b0;
      end else if (w_clear) begin
         r_state        <= c_GET_A;
         r_op_a         <= '0;
         r_op_b         <= '0;
         r_op_sub       <= 1'b0;
         r_res          <= '0;
         r_carry        <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         case (r_state)
            c_GET_A: begin
               if (w_enter) begin
                  r_op_a  <= sw_data;
                  r_state <= c_GET_B;
               end
            end
            c_GET_B: begin
               if (w_enter) begin
                  r_op_b   <= sw_data;
                  r_op_sub <= sw_sub;
                  r_state  <= c_CALC;
               end
            end
            c_CALC: begin
               r_res          <= adder_r;
               r_carry        <= adder_cout;
               r_result_valid <= 1'b1;
               r_state        <= c_SHOW;
            end
            default: begin
               if (w_enter) begin
                  r_result_valid <= 1'b0;
                  r_state        <= c_GET_A;
               end
            end
         endcase
      end
   end

   always_comb begin
      disp_nibble = sw_data;
      case (r_state)
         c_CALC:  disp_nibble = r_op_b;
         c_SHOW:  disp_nibble = r_res;
         default: disp_nibble = sw_data;
      endcase
   end

   assign op_a         = r_op_a;
   assign op_b         = r_op_b;
   assign op_sub       = r_op_sub;
   assign state_led    = r_state;
   assign result_valid = r_result_valid;
   assign carry_led    = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_addsub_operand_ctrl.sv
// ============================================================================
// Module   : tb_addsub_operand_ctrl
// Purpose  : Self-checking bench for addsub_operand_ctrl with a 4-bit adder model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addsub_operand_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_enter_n = 1'b1;
   logic       key_clear_n = 1'b1;
   logic [3:0] sw_data = 4'h0;
   logic       sw_sub = 1'b0;
   logic [3:0] adder_r;
   logic       adder_cout;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic       op_sub;
   logic [3:0] disp_nibble;
   logic [1:0] state_led;
   logic       result_valid;
   logic       carry_led;
`ifdef ADDSUB_OVF_DETECT_EN
   logic       ovf_led;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] res;
      logic       carry;
      logic       ovf;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   // External four_bit_adder: r/cout = a + (b ^ {4{s}}) + s
   logic [4:0] w_sum;
   assign w_sum      = {1'b0, op_a} + {1'b0, op_b ^ {4{op_sub}}} + {4'b0, op_sub};
   assign adder_r    = w_sum[3:0];
   assign adder_cout = w_sum[4];

   addsub_operand_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .key_enter_n(key_enter_n),
      .key_clear_n(key_clear_n),
      .sw_data(sw_data),
      .sw_sub(sw_sub),
      .adder_r(adder_r),
      .adder_cout(adder_cout),
      .op_a(op_a),
      .op_b(op_b),
      .op_sub(op_sub),
      .disp_nibble(disp_nibble),
      .state_led(state_led),
      .result_valid(result_valid),
      .carry_led(carry_led)
`ifdef ADDSUB_OVF_DETECT_EN
      ,
      .ovf_led(ovf_led)
`endif
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Hold the selected keys low long enough to debounce, then release.
   task automatic press_key(input bit ent, input bit clr);
      key_enter_n = ~ent;
      key_clear_n = ~clr;
      tick(12);
      key_enter_n = 1'b1;
      key_clear_n = 1'b1;
      tick(12);
   endtask

   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic sub);
      exp_t e;
      int   ua, ub, sa, sb, v;
      ua = int'(a);
      ub = int'(b);
      sa = a[3] ? ua - 16 : ua;
      sb = b[3] ? ub - 16 : ub;
      if (sub) begin
         e.res   = 4'((ua - ub + 16) % 16);
         e.carry = (ua >= ub);
         v       = sa - sb;
      end else begin
         e.res   = 4'((ua + ub) % 16);
         e.carry = (ua + ub) > 15;
         v       = sa + sb;
      end
      e.ovf = (v > 7) || (v < -8);
      return e;
   endfunction

   task automatic enter_a(input logic [3:0] v);
      sw_data = v;
      press_key(1'b1, 1'b0);
      n_checks++;
      if (state_led !== 2'b01 || op_a !== v) begin
         n_fail++;
         $display("FAIL enter_a: state=%b op_a=%h, required state=01 op_a=%h", state_led, op_a, v);
      end
   endtask

   // Enter B, check CALC/SHOW timing, then pop the scoreboard against the displayed result.
   task automatic enter_b(input logic [3:0] v, input logic sub);
      int   c;
      exp_t e;
      sb_q.push_back(model(op_a, v, sub));
      sw_data     = v;
      sw_sub      = sub;
      key_enter_n = 1'b0;
      c = 0;
      while (!result_valid && c < 20) begin
         tick(1);
         c++;
         if (c == 7) begin
            n_checks++;
            if (state_led !== 2'b10) begin
               n_fail++;
               $display("FAIL calc_state: state=%b, required 10", state_led);
            end
         end
      end
      n_checks++;
      if (c != 8 || state_led !== 2'b11) begin
         n_fail++;
         $display("FAIL show_latency: cycles=%0d state=%b, required 8 and 11", c, state_led);
      end
      e = sb_q.pop_front();
      n_checks++;
      if (disp_nibble !== e.res || carry_led !== e.carry) begin
         n_fail++;
         $display("FAIL result: disp=%h carry=%b, required disp=%h carry=%b",
                  disp_nibble, carry_led, e.res, e.carry);
      end
`ifdef ADDSUB_OVF_DETECT_EN
      n_checks++;
      if (ovf_led !== e.ovf) begin
         n_fail++;
         $display("FAIL ovf: ovf_led=%b, required %b", ovf_led, e.ovf);
      end
`endif
      key_enter_n = 1'b1;
      tick(12);
   endtask

   task automatic leave_show();
      press_key(1'b1, 1'b0);
      n_checks++;
      if (state_led !== 2'b00 || result_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL leave_show: state=%b rv=%b, required 00 and 0", state_led, result_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      n_checks++;
      if (state_led !== 2'b00 || op_a !== 4'h0 || op_b !== 4'h0 || op_sub !== 1'b0 ||
          result_valid !== 1'b0 || carry_led !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_held: state=%b a=%h b=%h sub=%b rv=%b c=%b, required all zero",
                  state_led, op_a, op_b, op_sub, result_valid, carry_led);
      end
      rst_n = 1'b1;
      tick(3);
      n_checks++;
      if (state_led !== 2'b00 || result_valid !== 1'b0 || disp_nibble !== sw_data) begin
         n_fail++;
         $display("FAIL reset_release: state=%b rv=%b disp=%h, required 00 0 %h",
                  state_led, result_valid, disp_nibble, sw_data);
      end
   endtask

   task automatic test_add();
      enter_a(4'h3);
      enter_b(4'h5, 1'b0);
      leave_show();
   endtask

   task automatic test_sub();
      enter_a(4'h3);
      enter_b(4'h5, 1'b1);
      leave_show();
   endtask

   task automatic test_wrap();
      enter_a(4'h7);
      enter_b(4'h1, 1'b0);
      leave_show();
      enter_a(4'hF);
      enter_b(4'h1, 1'b0);
      press_key(1'b0, 1'b1);
      n_checks++;
      if (state_led !== 2'b00 || result_valid !== 1'b0 || carry_led !== 1'b0 ||
          op_a !== 4'h0 || op_b !== 4'h0) begin
         n_fail++;
         $display("FAIL clear_show: state=%b rv=%b c=%b a=%h b=%h, required all zero",
                  state_led, result_valid, carry_led, op_a, op_b);
      end
   endtask

   task automatic test_bounce();
      sw_data = 4'h9;
      for (int i = 0; i < 10; i++) begin
         key_enter_n = ~key_enter_n;
         tick(2);
      end
      n_checks++;
      if (state_led !== 2'b00) begin
         n_fail++;
         $display("FAIL bounce_settle: state=%b, required 00", state_led);
      end
      key_enter_n = 1'b0;
      tick(12);
      key_enter_n = 1'b1;
      tick(12);
      n_checks++;
      if (state_led !== 2'b01 || op_a !== 4'h9) begin
         n_fail++;
         $display("FAIL bounce_once: state=%b a=%h, required 01 and 9", state_led, op_a);
      end
      key_enter_n = 1'b0;
      tick(3);
      key_enter_n = 1'b1;
      tick(12);
      n_checks++;
      if (state_led !== 2'b01) begin
         n_fail++;
         $display("FAIL glitch: state=%b, required 01", state_led);
      end
   endtask

   task automatic test_clear_enter();
      enter_b(4'h2, 1'b0);
      leave_show();
      enter_a(4'h4);
      sw_data = 4'h6;
      sw_sub  = 1'b1;
      press_key(1'b1, 1'b1);
      n_checks++;
      if (state_led !== 2'b00 || op_a !== 4'h0 || op_b !== 4'h0 || op_sub !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_enter: state=%b a=%h b=%h sub=%b, required 00 0 0 0",
                  state_led, op_a, op_b, op_sub);
      end
   endtask

   task automatic test_reset_calc();
      enter_a(4'h2);
      sw_data     = 4'h3;
      sw_sub      = 1'b0;
      key_enter_n = 1'b0;
      tick(7);
      n_checks++;
      if (state_led !== 2'b10) begin
         n_fail++;
         $display("FAIL pre_reset_calc: state=%b, required 10", state_led);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if (state_led !== 2'b00 || op_a !== 4'h0 || op_b !== 4'h0 || op_sub !== 1'b0 ||
          result_valid !== 1'b0 || carry_led !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: state=%b a=%h b=%h sub=%b rv=%b c=%b, required all zero",
                  state_led, op_a, op_b, op_sub, result_valid, carry_led);
      end
      key_enter_n = 1'b1;
      tick(1);
      rst_n = 1'b1;
      tick(12);
      n_checks++;
      if (state_led !== 2'b00 || op_a !== 4'h0) begin
         n_fail++;
         $display("FAIL post_reset: state=%b a=%h, required 00 and 0", state_led, op_a);
      end
   endtask

   initial begin
      tick(1);
      test_reset();
      test_add();
      test_sub();
      test_wrap();
      test_bounce();
      test_clear_enter();
      test_reset_calc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
